// File: rtl/error_monitor_reader.sv
// Computer-side reader for the LVDA error monitor latches: synchronises the
// active-low flags, returns one 13-bit group per request and optionally clears and verifies it.
module error_monitor_reader #(
   parameter int CLR_CYCLES    = 4,
   parameter int SETTLE_CYCLES = 3
) (
   input  logic        SIM_CLK,
   input  logic        SIM_RST,
   input  logic [25:0] EMN,
   input  logic        RD_REQ,
   input  logic        RD_GRP,
   input  logic        RD_CLR,
   output logic [12:0] RD_DATA,
   output logic        RD_ACK,
   output logic [1:0]  EMRS_REQ,
   output logic        BUSY,
   output logic [1:0]  STUCK,
   output logic        ANY_ERR
);

   if (CLR_CYCLES < 1 || CLR_CYCLES > 15) begin : g_bad_clr_cycles
      $error("CLR_CYCLES must be in 1..15");
   end
   if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 15) begin : g_bad_settle_cycles
      $error("SETTLE_CYCLES must be in 2..15");
   end

   localparam logic [3:0] CLR_LOAD    = 4'(CLR_CYCLES);
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      SNAP,
      ACK,
      CLEAR,
      SETTLE,
      VERIFY
   } state_t;

   state_t      state_q, state_d;
   logic [25:0] sync1_q, sync1_d;
   logic [25:0] sync2_q, sync2_d;
   logic        any_err_q, any_err_d;
   logic        grp_q, grp_d;
   logic        clr_q, clr_d;
   logic [12:0] snap_q, snap_d;
   logic [12:0] rd_data_q, rd_data_d;
   logic        rd_ack_q, rd_ack_d;
   logic [1:0]  emrs_q, emrs_d;
   logic [1:0]  stuck_q, stuck_d;
   logic [3:0]  cnt_q, cnt_d;

   logic [25:0] err;
   logic [12:0] grp_err;

   assign err     = ~sync2_q;
   assign grp_err = grp_q ? err[25:13] : err[12:0];

   // Synchroniser flops reset to all ones so that reset reads as "no error".
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         state_q   <= IDLE;
         sync1_q   <= '1;
         sync2_q   <= '1;
         any_err_q <= 1'b0;
         grp_q     <= 1'b0;
         clr_q     <= 1'b0;
         snap_q    <= '0;
         rd_data_q <= '0;
         rd_ack_q  <= 1'b0;
         emrs_q    <= 2'b00;
         stuck_q   <= 2'b00;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         any_err_q <= any_err_d;
         grp_q     <= grp_d;
         clr_q     <= clr_d;
         snap_q    <= snap_d;
         rd_data_q <= rd_data_d;
         rd_ack_q  <= rd_ack_d;
         emrs_q    <= emrs_d;
         stuck_q   <= stuck_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sync1_d   = EMN;
      sync2_d   = sync1_q;
      any_err_d = |err;
      grp_d     = grp_q;
      clr_d     = clr_q;
      snap_d    = snap_q;
      rd_data_d = rd_data_q;
      cnt_d     = cnt_q;
      stuck_d   = stuck_q;

      unique case (state_q)
         IDLE: begin
            if (RD_REQ) begin
               grp_d   = RD_GRP;
               clr_d   = RD_CLR;
               state_d = SNAP;
            end
         end
         SNAP: begin
            rd_data_d = grp_err;
            snap_d    = grp_err;
            state_d   = ACK;
         end
         ACK: begin
            if (clr_q) begin
               cnt_d   = CLR_LOAD;
               state_d = CLEAR;
            end else begin
               state_d = IDLE;
            end
         end
         CLEAR: begin
            if (cnt_q <= 4'd1) begin
               cnt_d   = SETTLE_LOAD;
               state_d = SETTLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         SETTLE: begin
            if (cnt_q <= 4'd1) begin
               state_d = VERIFY;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         VERIFY: begin
            // Only flags present in the snapshot can be declared stuck.
            if (|(snap_q & grp_err)) begin
               stuck_d[grp_q] = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Strobes are decoded from the next state so the outputs come straight from flops.
      rd_ack_d = (state_d == ACK);
      emrs_d   = 2'b00;
      if (state_d == CLEAR) begin
         emrs_d[grp_d] = 1'b1;
      end
   end

   assign RD_DATA  = rd_data_q;
   assign RD_ACK   = rd_ack_q;
   assign EMRS_REQ = emrs_q;
   assign BUSY     = (state_q != IDLE);
   assign STUCK    = stuck_q;
   assign ANY_ERR  = any_err_q;

endmodule

// File: tb/tb_error_monitor_reader.sv
// Self-checking bench for error_monitor_reader: table rows, hand-written corner
// sequences and randomised reads against a latch-level reference model.
module tb_error_monitor_reader;

   localparam int CLR_CYCLES    = 4;
   localparam int SETTLE_CYCLES = 3;

   logic        SIM_CLK = 1'b0;
   logic        SIM_RST;
   logic [25:0] EMN;
   logic        RD_REQ;
   logic        RD_GRP;
   logic        RD_CLR;
   logic [12:0] RD_DATA;
   logic        RD_ACK;
   logic [1:0]  EMRS_REQ;
   logic        BUSY;
   logic [1:0]  STUCK;
   logic        ANY_ERR;

   // The bench plays the latch hardware: latch bit = 1 means error latched,
   // mask bit = 1 means that latch ignores its reset strobe.
   logic [25:0] latch;
   logic [25:0] mask;
   logic [1:0]  stuck_model;
   int          vectors;
   int          miscompares;

   assign EMN = ~latch;

   error_monitor_reader #(
      .CLR_CYCLES   (CLR_CYCLES),
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) dut (
      .SIM_CLK (SIM_CLK),
      .SIM_RST (SIM_RST),
      .EMN     (EMN),
      .RD_REQ  (RD_REQ),
      .RD_GRP  (RD_GRP),
      .RD_CLR  (RD_CLR),
      .RD_DATA (RD_DATA),
      .RD_ACK  (RD_ACK),
      .EMRS_REQ(EMRS_REQ),
      .BUSY    (BUSY),
      .STUCK   (STUCK),
      .ANY_ERR (ANY_ERR)
   );

   always #5 SIM_CLK = ~SIM_CLK;

   typedef struct {
      logic [25:0] latch_v;
      logic [25:0] mask_v;
      logic        grp;
      logic        clr;
      logic [12:0] exp_data;
      logic [1:0]  exp_stuck;
      logic        exp_any;
   } vec_t;

   vec_t table_v[5];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock at the falling edge; a latch whose strobe is high clears unless masked.
   task automatic tick();
      @(negedge SIM_CLK);
      if (EMRS_REQ[0]) latch[12:0] = latch[12:0] & mask[12:0];
      if (EMRS_REQ[1]) latch[25:13] = latch[25:13] & mask[25:13];
   endtask

   task automatic apply_stimulus(input logic [25:0] latch_v, input logic [25:0] mask_v);
      latch = latch_v;
      mask  = mask_v;
      repeat (4) tick();
   endtask

   function automatic logic [12:0] group_of(input logic [25:0] v, input logic g);
      return g ? v[25:13] : v[12:0];
   endfunction

   // Full transaction: latency, data, strobe length and shape, busy length, sticky status.
   task automatic run_txn(input logic grp, input logic clr, input logic [12:0] exp_data,
                          input logic [1:0] exp_stuck, input int late_bit);
      int          t = 0;
      int          n_ack = 0;
      int          ack_at = -1;
      int          n_emrs = 0;
      int          bad_emrs = 0;
      int          n_busy = 0;
      bit          done = 0;
      bit          seen_emrs = 0;
      bit          injected = 0;
      logic [12:0] data_at_ack = '0;
      logic [1:0]  onehot;
      onehot = grp ? 2'b10 : 2'b01;
      RD_REQ = 1'b1;
      RD_GRP = grp;
      RD_CLR = clr;
      while (!done && t < 40) begin
         tick();
         t++;
         RD_REQ = 1'b0;
         if (RD_ACK) begin
            n_ack++;
            if (ack_at < 0) ack_at = t;
            data_at_ack = RD_DATA;
         end
         if (EMRS_REQ == onehot) begin
            n_emrs++;
            seen_emrs = 1;
         end else if (EMRS_REQ != 2'b00) begin
            bad_emrs++;
         end else if (seen_emrs && late_bit >= 0 && !injected) begin
            latch[late_bit] = 1'b1;
            injected = 1;
         end
         if (BUSY) n_busy++;
         else done = 1;
      end
      check_output("txn_timeout", 32'(done), 32'd1);
      check_output("ack_latency", 32'(ack_at), 32'd2);
      check_output("ack_count", 32'(n_ack), 32'd1);
      check_output("rd_data", 32'(data_at_ack), 32'(exp_data));
      check_output("emrs_cycles", 32'(n_emrs), clr ? 32'(CLR_CYCLES) : 32'd0);
      check_output("emrs_shape", 32'(bad_emrs), 32'd0);
      check_output("busy_cycles", 32'(n_busy), clr ? 32'(3 + CLR_CYCLES + SETTLE_CYCLES) : 32'd2);
      check_output("stuck", 32'(STUCK), 32'(exp_stuck));
      check_output("rd_data_hold", 32'(RD_DATA), 32'(exp_data));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      stuck_model = 2'b00;
      SIM_RST     = 1'b0;
      RD_REQ      = 1'b0;
      RD_GRP      = 1'b0;
      RD_CLR      = 1'b0;
      latch       = '0;
      mask        = '0;

      table_v[0] = '{26'h0000008, 26'h0000000, 1'b0, 1'b0, 13'h0008, 2'b00, 1'b1};
      table_v[1] = '{26'h1000000, 26'h0000000, 1'b1, 1'b1, 13'h0800, 2'b00, 1'b1};
      table_v[2] = '{26'h1000000, 26'h1000000, 1'b1, 1'b1, 13'h0800, 2'b10, 1'b1};
      table_v[3] = '{26'h0000000, 26'h0000000, 1'b0, 1'b0, 13'h0000, 2'b10, 1'b0};
      table_v[4] = '{26'h2002000, 26'h0000000, 1'b1, 1'b0, 13'h1001, 2'b10, 1'b1};

      repeat (2) tick();
      check_output("rst_rd_data", 32'(RD_DATA), 32'd0);
      check_output("rst_emrs", 32'(EMRS_REQ), 32'd0);
      check_output("rst_busy", 32'(BUSY), 32'd0);
      SIM_RST = 1'b1;
      repeat (4) tick();
      check_output("rst_rd_ack", 32'(RD_ACK), 32'd0);
      check_output("rst_stuck", 32'(STUCK), 32'd0);
      check_output("rst_any_err", 32'(ANY_ERR), 32'd0);
      check_output("rst_busy_after", 32'(BUSY), 32'd0);

      for (int i = 0; i < 5; i++) begin
         apply_stimulus(table_v[i].latch_v, table_v[i].mask_v);
         check_output("tbl_any_err", 32'(ANY_ERR), 32'(table_v[i].exp_any));
         run_txn(table_v[i].grp, table_v[i].clr, table_v[i].exp_data, table_v[i].exp_stuck, -1);
         stuck_model = table_v[i].exp_stuck;
      end

      // Error arriving during SETTLE is outside the snapshot and stays for the next read.
      apply_stimulus(26'h0000001, 26'h0000000);
      run_txn(1'b0, 1'b1, 13'h0001, stuck_model, 5);
      repeat (3) tick();
      run_txn(1'b0, 1'b0, 13'h0020, stuck_model, -1);

      for (int i = 0; i < 25; i++) begin
         logic [25:0] l;
         logic [25:0] m;
         logic        g;
         logic        c;
         l = 26'($urandom);
         m = ($urandom_range(0, 3) == 0) ? (l & (26'd1 << $urandom_range(0, 25))) : 26'd0;
         g = 1'($urandom_range(0, 1));
         c = 1'($urandom_range(0, 1));
         apply_stimulus(l, m);
         check_output("rnd_any_err", 32'(ANY_ERR), 32'(|l));
         if (c && (group_of(l & m, g) != 13'd0)) stuck_model[g] = 1'b1;
         run_txn(g, c, group_of(l, g), stuck_model, -1);
      end

      // Request during CLEAR is dropped; then reset lands in the middle of CLEAR.
      apply_stimulus(26'h0000004, 26'h0000000);
      RD_REQ = 1'b1;
      RD_GRP = 1'b0;
      RD_CLR = 1'b1;
      begin
         int  t = 0;
         int  extra_ack = 0;
         while (EMRS_REQ == 2'b00 && t < 20) begin
            tick();
            t++;
            RD_REQ = 1'b0;
         end
         check_output("clr_reached", 32'(EMRS_REQ), 32'b01);
         RD_REQ = 1'b1;
         tick();
         if (RD_ACK) extra_ack++;
         RD_REQ = 1'b0;
         tick();
         if (RD_ACK) extra_ack++;
         check_output("ignored_req_ack", 32'(extra_ack), 32'd0);
         check_output("still_clearing", 32'(EMRS_REQ), 32'b01);
      end
      #2 SIM_RST = 1'b0;
      #1;
      check_output("async_rst_emrs", 32'(EMRS_REQ), 32'd0);
      check_output("async_rst_busy", 32'(BUSY), 32'd0);
      check_output("async_rst_stuck", 32'(STUCK), 32'd0);
      check_output("async_rst_rd_data", 32'(RD_DATA), 32'd0);
      check_output("async_rst_any_err", 32'(ANY_ERR), 32'd0);
      stuck_model = 2'b00;
      tick();
      SIM_RST = 1'b1;
      repeat (4) tick();
      check_output("post_rst_latch_cleared", 32'(ANY_ERR), 32'(|latch));
      run_txn(1'b0, 1'b0, group_of(latch, 1'b0), stuck_model, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
